pc_gen: RTL

//  Next-generation fetch PC generator. Replaces the plain enable-gated PC register with
//  on-chip next-PC selection: sequential increment (+4, or +2 for compressed), EX-stage

---
 rtl/pc_gen_pkg.sv | 30 +++
 rtl/pc_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator: FSM states, next-PC
// source selector and instruction step sizes.
package pc_gen_pkg;

  localparam int XLEN         = 32;
  localparam int INSTR_BYTES  = 4;
  localparam int CINSTR_BYTES = 2;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_PENDING
  } pc_state_e;

  // Source of the PC register's next value.
  typedef enum logic [2:0] {
    PC_SEL_HOLD,
    PC_SEL_RESET,
    PC_SEL_TARGET,
    PC_SEL_PENDING,
    PC_SEL_SEQ
  } pc_sel_e;

  // Byte distance to the next sequential instruction.
  function automatic int unsigned step_bytes(input logic compressed_en,
                                             input logic is_compressed);
    return (compressed_en && is_compressed) ? CINSTR_BYTES : INSTR_BYTES;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential increment, EX/trap redirect with stall-time
// pending capture, and an epoch tag that advances on every accepted redirect.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH    = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter bit                    COMPRESSED_EN = 1'b0,
  parameter int                    EPOCH_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   ex_redirect_i,
  input  logic [DATA_WIDTH-1:0]  ex_target_i,
  input  logic                   trap_i,
  input  logic [DATA_WIDTH-1:0]  trap_vector_i,
  input  logic                   instr_is_compressed_i,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic                   pc_valid_o,
  output logic [EPOCH_WIDTH-1:0] epoch_o,
  output logic                   misaligned_o
);

  // Bits forced to zero in any redirect target (IALIGN=16 or IALIGN=32).
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK =
    COMPRESSED_EN ? ~DATA_WIDTH'(1) : ~DATA_WIDTH'(3);

  pc_state_e             state_q, state_d;
  pc_sel_e               pc_sel;
  logic                  capture_pending;
  logic                  valid_d;

  logic [DATA_WIDTH-1:0]  pc_q;
  logic [DATA_WIDTH-1:0]  pending_q;
  logic [EPOCH_WIDTH-1:0] epoch_q;
  logic                   valid_q;
  logic                   misaligned_q;

  logic                  redirect;
  logic [DATA_WIDTH-1:0] raw_target;
  logic [DATA_WIDTH-1:0] target_aligned;
  logic                  target_misaligned;
  logic [DATA_WIDTH-1:0] seq_pc;

  // Trap outranks the EX redirect; both collapse into a single accepted redirect.
  assign redirect          = trap_i | ex_redirect_i;
  assign raw_target        = trap_i ? trap_vector_i : ex_target_i;
  assign target_aligned    = raw_target & ALIGN_MASK;
  assign target_misaligned = |(raw_target & ~ALIGN_MASK);

  assign seq_pc = pc_q + DATA_WIDTH'(step_bytes(COMPRESSED_EN, instr_is_compressed_i));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PC_BOOT;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves a
  // variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = stall_i ? PC_PENDING : PC_RUN;
    end else begin
      unique case (state_q)
        PC_BOOT:    state_d = stall_i ? PC_BOOT : PC_RUN;
        PC_RUN:     state_d = PC_RUN;
        PC_PENDING: state_d = stall_i ? PC_PENDING : PC_RUN;
        default:    state_d = PC_BOOT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output/control decode (drives the datapath registers below)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_sel          = PC_SEL_HOLD;
    capture_pending = 1'b0;
    valid_d         = valid_q;
    if (redirect) begin
      // A redirect behaves the same from any state; a stall only defers it.
      if (stall_i) begin
        capture_pending = 1'b1;
        valid_d         = 1'b0;
      end else begin
        pc_sel  = PC_SEL_TARGET;
        valid_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        PC_BOOT: begin
          if (!stall_i) begin
            pc_sel  = PC_SEL_RESET;
            valid_d = 1'b1;
          end
        end
        PC_RUN: begin
          if (!stall_i) begin
            pc_sel  = PC_SEL_SEQ;
            valid_d = 1'b1;
          end
        end
        PC_PENDING: begin
          if (stall_i) begin
            valid_d = 1'b0;
          end else begin
            pc_sel  = PC_SEL_PENDING;
            valid_d = 1'b1;
          end
        end
        default: begin
          pc_sel  = PC_SEL_HOLD;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      unique case (pc_sel)
        PC_SEL_RESET:   pc_q <= RESET_VECTOR;
        PC_SEL_TARGET:  pc_q <= target_aligned;
        PC_SEL_PENDING: pc_q <= pending_q;
        PC_SEL_SEQ:     pc_q <= seq_pc;
        default:        pc_q <= pc_q;
      endcase
    end
  end

  // Cleared on reset so a redirect deferred before reset can never resurface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pending_q <= '0;
    else if (capture_pending) pending_q <= target_aligned;
  end

  // Wraps naturally at 2^EPOCH_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           epoch_q <= '0;
    else if (redirect) epoch_q <= epoch_q + EPOCH_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      misaligned_q <= redirect & target_misaligned;
    end
  end

  assign pc_o         = pc_q;
  assign pc_valid_o   = valid_q;
  assign epoch_o      = epoch_q;
  assign misaligned_o = misaligned_q;

endmodule
